md5_pipe_core: RTL and testbench

Fully pipelined two-block MD5 compression engine: accepts one 1024-bit input per clock and returns the 128-bit MD5 chaining result after both 512-bit blocks are compressed from the standard IV. No padding or length append is done inside the block; the caller supplies pre-formatted blocks. Two instances are chained in the sentry HMAC engine: inner hash of key-pad plus line, then outer hash.

---
 rtl/md5_pipe_core.sv | 161 ++++++++++++++++
 tb/tb_md5_pipe_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/md5_pipe_core.sv
// Fully pipelined two-block MD5 compression: one 1024-bit input per clock, 128 round stages.
// Define MD5_PIPE_OUTREG_EN to add an output register (latency 129 instead of 128).
module md5_pipe_core (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [1023:0] in,
    output logic          ready,
    output logic [127:0]  out
);

    localparam logic [127:0] IV = 128'h67452301_efcdab89_98badcfe_10325476;

    localparam logic [31:0] TK [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] SH [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [127:0] add4(input logic [127:0] x, input logic [127:0] y);
        return {x[127:96] + y[127:96], x[95:64] + y[95:64], x[63:32] + y[63:32], x[31:0] + y[31:0]};
    endfunction

    function automatic logic [127:0] to_out(input logic [127:0] x);
        return {bswap(x[127:96]), bswap(x[95:64]), bswap(x[63:32]), bswap(x[31:0])};
    endfunction

    // One MD5 round; r is the global round index 0..127, state packed as {A,B,C,D}.
    function automatic logic [127:0] md5_round(input logic [127:0] st, input logic [511:0] blk,
                                               input int r);
        logic [31:0]  a, b, c, d, f, m, tmp, rot;
        logic [5:0]   rr;
        logic [3:0]   k;
        logic [4:0]   sh;
        logic [511:0] sft;
        rr = 6'(r);
        {a, b, c, d} = st;
        f = '0;
        k = '0;
        unique case (rr[5:4])
            2'd0: begin f = (b & c) | (~b & d); k = rr[3:0];        end
            2'd1: begin f = (d & b) | (~d & c); k = 4'(5 * rr + 1); end
            2'd2: begin f = b ^ c ^ d;          k = 4'(3 * rr + 5); end
            2'd3: begin f = c ^ (b | ~d);       k = 4'(7 * rr);     end
        endcase
        // Word 0 sits in the top 32 bits; bytes inside each word are little-endian.
        sft = blk << {k, 5'd0};
        m   = bswap(sft[511:480]);
        sh  = SH[{rr[5:4], rr[1:0]}];
        tmp = a + f + TK[rr] + m;
        rot = (tmp << sh) | (tmp >> (32 - sh));
        return {d, b + rot, b, c};
    endfunction

    logic [127:0] vld_q;
    logic [127:0] vld_in;
    logic [127:0] st_q   [127];
    logic [511:0] blk0_q [63];
    logic [511:0] blk1_q [127];
    logic [127:0] h_q    [64:126];
    logic [127:0] rnd    [128];
    logic [127:0] dig_q;

    assign vld_in = {vld_q[126:0], req};

    assign rnd[0] = md5_round(IV, in[1023:512], 0);
    for (genvar i = 1; i < 128; i++) begin : g_rnd
        if (i < 64) begin : g_b0
            assign rnd[i] = md5_round(st_q[i-1], blk0_q[i-1], i);
        end else begin : g_b1
            assign rnd[i] = md5_round(st_q[i-1], blk1_q[i-1], i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_in;
    end

    // Data registers have no reset and load only with a valid item, so bubbles leave them alone.
    for (genvar i = 0; i < 127; i++) begin : g_st
        always_ff @(posedge clk) begin
            if (vld_in[i]) st_q[i] <= (i == 63) ? add4(rnd[i], IV) : rnd[i];
        end
    end

    always_ff @(posedge clk) begin
        if (vld_in[0]) begin
            blk0_q[0] <= in[1023:512];
            blk1_q[0] <= in[511:0];
        end
    end

    for (genvar i = 1; i < 63; i++) begin : g_blk0
        always_ff @(posedge clk) begin
            if (vld_in[i]) blk0_q[i] <= blk0_q[i-1];
        end
    end

    for (genvar i = 1; i < 127; i++) begin : g_blk1
        always_ff @(posedge clk) begin
            if (vld_in[i]) blk1_q[i] <= blk1_q[i-1];
        end
    end

    // H1 rides along with block 1 for the final feed-forward.
    for (genvar i = 64; i < 127; i++) begin : g_h
        always_ff @(posedge clk) begin
            if (vld_in[i]) h_q[i] <= (i == 64) ? st_q[63] : h_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)               dig_q <= '0;
        else if (vld_in[127])  dig_q <= to_out(add4(rnd[127], h_q[126]));
    end

`ifdef MD5_PIPE_OUTREG_EN
    logic         ready_q;
    logic [127:0] out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            out_q   <= '0;
        end else begin
            ready_q <= vld_q[127];
            if (vld_q[127]) out_q <= dig_q;
        end
    end

    assign ready = ready_q;
    assign out   = out_q;
`else
    assign ready = vld_q[127];
    assign out   = dig_q;
`endif

endmodule

// File: tb/tb_md5_pipe_core.sv
// Directed bench for md5_pipe_core: software MD5 model, cycle-exact scoreboard, chained pair.
module tb_md5_pipe_core;

`ifdef MD5_PIPE_OUTREG_EN
    localparam int LAT = 129;
`else
    localparam int LAT = 128;
`endif

    localparam logic [127:0] IV   = 128'h67452301_efcdab89_98badcfe_10325476;
    localparam logic [511:0] OPAD = {64{8'h5c}};

    logic          clk;
    logic          rst;
    logic          req;
    logic [1023:0] in_data;
    logic          ready;
    logic [127:0]  out;
    logic          ready2;
    logic [127:0]  out2;
    logic [1023:0] in2;

    assign in2 = {OPAD, out, 384'd0};

    md5_pipe_core u_inner (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .in    (in_data),
        .ready (ready),
        .out   (out)
    );

    md5_pipe_core u_outer (
        .clk   (clk),
        .rst   (rst),
        .req   (ready),
        .in    (in2),
        .ready (ready2),
        .out   (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [127:0] dig;
    } exp_t;

    exp_t         q1[$];
    exp_t         q2[$];
    logic [127:0] last1;
    logic [127:0] last2;
    int           cyc   = 0;
    int           total = 0;
    int           bad   = 0;

    logic [31:0] tk [64];
    int sh_tab [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

    function automatic logic [31:0] bsw(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [7:0] byte_at(input logic [511:0] blk, input int n);
        logic [511:0] t;
        t = blk >> (8 * (63 - n));
        return t[7:0];
    endfunction

    // Reference compression of one 512-bit block, state as {A,B,C,D}.
    function automatic logic [127:0] model_blk(input logic [127:0] h, input logic [511:0] blk);
        logic [31:0] m [16];
        logic [31:0] a, b, c, d, f, tmp;
        int          g, s, grp;
        for (int j = 0; j < 16; j++) begin
            m[j[3:0]] = {byte_at(blk, 4*j+3), byte_at(blk, 4*j+2),
                         byte_at(blk, 4*j+1), byte_at(blk, 4*j)};
        end
        a = h[127:96]; b = h[95:64]; c = h[63:32]; d = h[31:0];
        for (int i = 0; i < 64; i++) begin
            grp = i / 16;
            if (grp == 0)      begin f = (b & c) | (~b & d); g = i;              end
            else if (grp == 1) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (grp == 2) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else               begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            s   = sh_tab[grp[1:0]][i[1:0]];
            tmp = f + a + tk[i[5:0]] + m[g[3:0]];
            a = d; d = c; c = b;
            b = b + ((tmp << s) | (tmp >> (32 - s)));
        end
        return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
    endfunction

    function automatic logic [127:0] to_hex(input logic [127:0] x);
        return {bsw(x[127:96]), bsw(x[95:64]), bsw(x[63:32]), bsw(x[31:0])};
    endfunction

    function automatic logic [127:0] md5_two(input logic [1023:0] d);
        return to_hex(model_blk(model_blk(IV, d[1023:512]), d[511:0]));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one cycle, advance the scoreboard, then check both instances #1 after the edge.
    task automatic tick(input logic r, input logic q, input logic [1023:0] d);
        rst = r; req = q; in_data = d;
        @(posedge clk);
        cyc++;
        if (r) begin
            q1.delete(); q2.delete();
            last1 = '0; last2 = '0;
        end else if (q) begin
            q1.push_back('{cyc + LAT - 1, md5_two(d)});
        end
        #1;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("ready1", {127'd0, ready}, 128'd1);
            chk("out1", out, q1[0].dig);
            last1 = q1[0].dig;
            q2.push_back('{cyc + LAT, md5_two({OPAD, q1[0].dig, 384'd0})});
            void'(q1.pop_front());
        end else begin
            chk("ready1_idle", {127'd0, ready}, 128'd0);
            chk("out1_hold", out, last1);
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            chk("ready2", {127'd0, ready2}, 128'd1);
            chk("out2", out2, q2[0].dig);
            last2 = q2[0].dig;
            void'(q2.pop_front());
        end else begin
            chk("ready2_idle", {127'd0, ready2}, 128'd0);
            chk("out2_hold", out2, last2);
        end
    endtask

    logic [511:0]  abc_blk;
    logic [1023:0] known;
    logic [7:0]    b8;
    real           x;
    longint        lt;

    initial begin
        rst = 1'b1; req = 1'b0; in_data = '0;
        last1 = '0; last2 = '0;

        for (int i = 0; i < 64; i++) begin
            x = $sin(real'(i + 1));
            if (x < 0.0) x = -x;
            x  = $floor(x * 4294967296.0);
            lt = longint'(x);
            tk[i] = lt[31:0];
        end

        // Model sanity: single-block MD5("abc").
        abc_blk = {8'h61, 8'h62, 8'h63, 8'h80, 416'd0, 8'h18, 56'd0};
        chk("model_abc", to_hex(model_blk(IV, abc_blk)), 128'h900150983cd24fb0d6963f7d28e17f72);

        // Reset, then a long idle stretch.
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, '0);
        for (int i = 0; i < 200; i++) tick(1'b0, 1'b0, '0);

        // Known vector: 64 x 'a' with standard padding in block 1.
        known = {{64{8'h61}}, 8'h80, 440'd0, 8'h00, 8'h02, 48'd0};
        tick(1'b0, 1'b1, known);
        for (int i = 0; i < LAT + 4; i++) tick(1'b0, 1'b0, '0);

        // Back-to-back streaming.
        for (int i = 0; i < 256; i++) begin
            b8 = 8'(i);
            tick(1'b0, 1'b1, {504'd0, b8, 512'd0});
        end
        for (int i = 0; i < LAT + 4; i++) tick(1'b0, 1'b0, '0);

        // Alternating requests, then a gap.
        for (int i = 0; i < 40; i++) begin
            b8 = 8'(i * 37 + 3);
            tick(1'b0, (i % 2) == 0, {128{b8}});
        end
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b0, '0);
        for (int i = 0; i < 2 * LAT + 10; i++) tick(1'b0, 1'b0, '0);

        // Reset mid-flight, with a request coinciding with the reset cycle.
        for (int i = 0; i < 5; i++) begin
            b8 = 8'(200 + i);
            tick(1'b0, 1'b1, {128{b8}});
        end
        for (int i = 0; i < 60; i++) tick(1'b0, 1'b0, '0);
        tick(1'b1, 1'b1, {128{8'h33}});
        for (int i = 0; i < 2 * LAT + 10; i++) tick(1'b0, 1'b0, '0);

        chk("drain1", 128'(q1.size()), 128'd0);
        chk("drain2", 128'(q2.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
